alu_issue_arbiter: RTL

Shares the single register-read/ALU stage between two issue lanes of the dual-issue scheduler. Each lane gets a small FIFO. A round-robin arbiter selects one instruction per cycle into a registered output slot, which drives the ALU stage's `issue_instr_i` and `issue_valid_i` inputs. The block supports downstream backpressure and a pipeline flush.

---
 rtl/alu_issue_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/alu_issue_arbiter.sv
// Two-lane issue arbiter: a small FIFO per lane, a round-robin pick of one head
// per cycle into a registered output slot, with downstream backpressure and flush.
module alu_issue_arbiter #(
    parameter int INSTR_W = 64,
    parameter int DEPTH   = 2,
    parameter int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic [INSTR_W-1:0] lane0_instr_i,
    input  logic               lane0_valid_i,
    output logic               lane0_ready_o,
    input  logic [INSTR_W-1:0] lane1_instr_i,
    input  logic               lane1_valid_i,
    output logic               lane1_ready_o,
    output logic [INSTR_W-1:0] issue_instr_o,
    output logic               issue_valid_o,
    output logic               issue_lane_o,
    input  logic               issue_ready_i,
    output logic [CNT_W-1:0]   lane0_count_o,
    output logic [CNT_W-1:0]   lane1_count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [INSTR_W-1:0] mem0 [DEPTH];
    logic [INSTR_W-1:0] mem1 [DEPTH];
    logic [PTR_W-1:0]   rd_ptr0, wr_ptr0, rd_ptr1, wr_ptr1;
    logic [CNT_W-1:0]   count0, count1;
    logic               last_grant;

    logic push0, push1, pop0, pop1;
    logic nonempty0, nonempty1;
    logic slot_free, grant;

    // Ready comes from registered occupancy only; a full FIFO never bypasses.
    assign lane0_ready_o = (count0 < CNT_W'(DEPTH)) && !flush_i;
    assign lane1_ready_o = (count1 < CNT_W'(DEPTH)) && !flush_i;
    assign push0         = lane0_valid_i && lane0_ready_o;
    assign push1         = lane1_valid_i && lane1_ready_o;

    assign nonempty0     = (count0 != '0);
    assign nonempty1     = (count1 != '0);
    assign slot_free     = !issue_valid_o || issue_ready_i;
    assign lane0_count_o = count0;
    assign lane1_count_o = count1;

    always_comb begin
        grant = last_grant;
        pop0  = 1'b0;
        pop1  = 1'b0;
        if (slot_free && !flush_i) begin
            if (nonempty0 && nonempty1) begin
                grant = !last_grant;
            end else if (nonempty0) begin
                grant = 1'b0;
            end else if (nonempty1) begin
                grant = 1'b1;
            end
            pop0 = nonempty0 && !grant;
            pop1 = nonempty1 && grant;
        end
    end

    // Storage has no reset: stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (push0) begin
            mem0[wr_ptr0] <= lane0_instr_i;
        end
        if (push1) begin
            mem1[wr_ptr1] <= lane1_instr_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            rd_ptr0 <= '0;
            wr_ptr0 <= '0;
            count0  <= '0;
            rd_ptr1 <= '0;
            wr_ptr1 <= '0;
            count1  <= '0;
        end else begin
            if (push0) begin
                wr_ptr0 <= wr_ptr0 + PTR_W'(1);
            end
            if (pop0) begin
                rd_ptr0 <= rd_ptr0 + PTR_W'(1);
            end
            if (push1) begin
                wr_ptr1 <= wr_ptr1 + PTR_W'(1);
            end
            if (pop1) begin
                rd_ptr1 <= rd_ptr1 + PTR_W'(1);
            end
            count0 <= count0 + CNT_W'(push0) - CNT_W'(pop0);
            count1 <= count1 + CNT_W'(push1) - CNT_W'(pop1);
        end
    end

    // Output slot: loads a head when free, otherwise holds its contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_valid_o <= 1'b0;
            issue_instr_o <= '0;
            issue_lane_o  <= 1'b0;
            last_grant    <= 1'b1;
        end else if (flush_i) begin
            issue_valid_o <= 1'b0;
            last_grant    <= 1'b1;
        end else if (slot_free) begin
            if (pop0 || pop1) begin
                issue_valid_o <= 1'b1;
                issue_instr_o <= grant ? mem1[rd_ptr1] : mem0[rd_ptr0];
                issue_lane_o  <= grant;
                last_grant    <= grant;
            end else begin
                issue_valid_o <= 1'b0;
            end
        end
    end

endmodule
